// File: rtl/keyin_pkg.sv
// Shared key codes, channel FSM encoding and a small width helper for the
// key debouncer/encoder.
package keyin_pkg;

   localparam int unsigned KEY_NONE  = 0;
   localparam int unsigned KEY_PAUSE = 1;
   localparam int unsigned KEY_UP    = 2;
   localparam int unsigned KEY_LEFT  = 3;
   localparam int unsigned KEY_DOWN  = 4;
   localparam int unsigned KEY_RIGHT = 5;

   typedef enum logic [1:0] {
      ST_RELEASED,
      ST_PRESS_CHK,
      ST_HELD,
      ST_REL_CHK
   } deb_state_e;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, press/release debounce FSM and
// auto-repeat timer. All event outputs are registered one-cycle pulses.
module key_debounce_ch
   import keyin_pkg::*;
#(
   parameter int unsigned DEB_CYCLES    = 500000,
   parameter bit          ACTIVE_LOW    = 1'b1,
   parameter bit          REPEAT_EN     = 1'b1,
   parameter int unsigned REPEAT_DELAY  = 12500000,
   parameter int unsigned REPEAT_PERIOD = 5000000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic key_raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic repeat_o
);

   localparam int unsigned CNT_W = $clog2(max3(DEB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic             s1_q, s2_q, act;
   deb_state_e       state_q, state_d;
   logic [CNT_W-1:0] deb_q, deb_d, rep_q, rep_d;
   logic             first_q, first_d;
   logic             press_q, press_d, release_q, release_d, repeat_q, repeat_d;

   assign act = ACTIVE_LOW ? ~s2_q : s2_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q      <= ACTIVE_LOW;
         s2_q      <= ACTIVE_LOW;
         state_q   <= ST_RELEASED;
         deb_q     <= '0;
         rep_q     <= '0;
         first_q   <= 1'b1;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         s1_q      <= key_raw_i;
         s2_q      <= s1_q;
         state_q   <= state_d;
         deb_q     <= deb_d;
         rep_q     <= rep_d;
         first_q   <= first_d;
         press_q   <= press_d;
         release_q <= release_d;
         repeat_q  <= repeat_d;
      end
   end

   // first_q selects the initial delay vs. the steady repeat period.
   always_comb begin
      state_d   = state_q;
      deb_d     = deb_q;
      rep_d     = rep_q;
      first_d   = first_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
         ST_RELEASED: begin
            if (act) begin
               state_d = ST_PRESS_CHK;
               deb_d   = ONE;
            end
         end
         ST_PRESS_CHK: begin
            if (!act) begin
               state_d = ST_RELEASED;
               deb_d   = '0;
            end else if (deb_q == DEB_LAST) begin
               state_d = ST_HELD;
               press_d = 1'b1;
               deb_d   = '0;
               rep_d   = '0;
               first_d = 1'b1;
            end else begin
               deb_d = deb_q + ONE;
            end
         end
         ST_HELD: begin
            if (!act) begin
               state_d = ST_REL_CHK;
               deb_d   = ONE;
            end else if (REPEAT_EN) begin
               if (rep_q == (first_q ? RD_LAST : RP_LAST)) begin
                  repeat_d = 1'b1;
                  rep_d    = '0;
                  first_d  = 1'b0;
               end else begin
                  rep_d = rep_q + ONE;
               end
            end
         end
         ST_REL_CHK: begin
            if (act) begin
               state_d = ST_HELD;
               deb_d   = '0;
            end else if (deb_q == DEB_LAST) begin
               state_d   = ST_RELEASED;
               release_d = 1'b1;
               deb_d     = '0;
               rep_d     = '0;
               first_d   = 1'b1;
            end else begin
               deb_d = deb_q + ONE;
            end
         end
         default: state_d = ST_RELEASED;
      endcase
   end

   assign level_o   = (state_q == ST_HELD) || (state_q == ST_REL_CHK);
   assign press_o   = press_q;
   assign release_o = release_q;
   assign repeat_o  = repeat_q;

endmodule

// File: rtl/key_debounce_enc.sv
// N independent debounced key channels plus a registered priority encoder
// that turns press/repeat events into a held key code and a strobe.
module key_debounce_enc
   import keyin_pkg::*;
#(
   parameter int unsigned        N_KEYS        = 5,
   parameter int unsigned        DEB_CYCLES    = 500000,
   parameter bit                 ACTIVE_LOW    = 1'b1,
   parameter logic [N_KEYS-1:0]  REPEAT_MASK   = 5'b11110,
   parameter int unsigned        REPEAT_DELAY  = 12500000,
   parameter int unsigned        REPEAT_PERIOD = 5000000,
   localparam int unsigned       CODE_W        = $clog2(N_KEYS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_raw,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release,
   output logic [N_KEYS-1:0] key_repeat,
   output logic [CODE_W-1:0] key_code,
   output logic              key_strobe,
   output logic              key_any
);

   logic [N_KEYS-1:0] ev;
   logic [CODE_W-1:0] code_q, code_d;
   logic              strobe_q, strobe_d;

   for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
      key_debounce_ch #(
         .DEB_CYCLES   (DEB_CYCLES),
         .ACTIVE_LOW   (ACTIVE_LOW),
         .REPEAT_EN    (REPEAT_MASK[g]),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_ch (
         .clk_i    (clk),
         .rst_i    (rst),
         .key_raw_i(key_raw[g]),
         .level_o  (key_level[g]),
         .press_o  (key_press[g]),
         .release_o(key_release[g]),
         .repeat_o (key_repeat[g])
      );
   end

   assign ev = key_press | key_repeat;

   // Ascending scan: the highest active channel overwrites lower ones.
   always_comb begin
      code_d   = code_q;
      strobe_d = 1'b0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
         if (ev[i]) begin
            code_d   = CODE_W'(i + 1);
            strobe_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         code_q   <= CODE_W'(KEY_NONE);
         strobe_q <= 1'b0;
      end else begin
         code_q   <= code_d;
         strobe_q <= strobe_d;
      end
   end

   assign key_code   = code_q;
   assign key_strobe = strobe_q;
   assign key_any    = |key_level;

endmodule
